// File: rtl/fnd_pkg.sv
// Shared constants, FSM state type and the pattern-to-ASCII decode table for the
// 7-segment display decoder. Patterns are active-low, bit6=g .. bit0=a.
package fnd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_PUSH   = 2'd2
    } fnd_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1011000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_J     = 7'b1110000;

    localparam logic [7:0] ASCII_BLANK = 8'h20;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;

    // Glyphs shared by a letter and a digit (D/0, B/8, I/1, G/6) resolve to the digit.
    function automatic logic [7:0] fnd_decode(input logic [6:0] pat);
        logic [7:0] code;
        case (pat)
            SEG_BLANK: code = ASCII_BLANK;
            SEG_0:     code = 8'h30;
            SEG_1:     code = 8'h31;
            SEG_2:     code = 8'h32;
            SEG_3:     code = 8'h33;
            SEG_4:     code = 8'h34;
            SEG_5:     code = 8'h35;
            SEG_6:     code = 8'h36;
            SEG_7:     code = 8'h37;
            SEG_8:     code = 8'h38;
            SEG_9:     code = 8'h39;
            SEG_A:     code = 8'h41;
            SEG_C:     code = 8'h43;
            SEG_E:     code = 8'h45;
            SEG_F:     code = 8'h46;
            SEG_H:     code = 8'h48;
            SEG_J:     code = 8'h4A;
            default:   code = ASCII_QMARK;
        endcase
        return code;
    endfunction

    function automatic logic fnd_is_mapped(input logic [6:0] pat);
        return fnd_decode(pat) != ASCII_QMARK;
    endfunction

endpackage

// File: rtl/fnd_decoder_if.sv
// Bundle of the segment input, the character output stream and status pulses.
// Handshake: a character transfers on a rising clk edge when dout_valid && dout_ready;
// dout_valid never depends on dout_ready and dout is held until that transfer happens.
interface fnd_decoder_if;
    logic [6:0]          seg_in;
    logic                dout_ready;
    logic [7:0]          dout;
    logic                dout_valid;
    logic [2:0]          level;
    logic                err;
    logic                ovf;
    fnd_pkg::fnd_state_t state;

    modport master (
        input  seg_in, dout_ready,
        output dout, dout_valid, level, err, ovf, state
    );

    modport slave (
        output seg_in, dout_ready,
        input  dout, dout_valid, level, err, ovf, state
    );
endinterface

// File: rtl/fnd_char_fifo.sv
// Four-entry, 8-bit character FIFO; head is read combinationally from storage.
module fnd_char_fifo (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic [2:0] level
);
    logic [7:0] mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       do_push;
    logic       do_pop;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 4; i++) begin
                mem[i] <= 8'h00;
            end
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == 3'd4);
    assign empty = (count == 3'd0);
    assign level = count;
endmodule

// File: rtl/fnd_decoder.sv
// Debounces a glitchy 7-segment pattern, decodes each newly accepted glyph to ASCII
// and queues it for a valid/ready consumer.
module fnd_decoder
    import fnd_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          n_rst,
    fnd_decoder_if.master bus
);
    localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);

    fnd_state_t state;
    fnd_state_t state_nx;
    logic [3:0] cnt;
    logic [3:0] cnt_nx;
    logic [6:0] seg_q;
    logic [6:0] last_pat;
    logic [6:0] last_pat_nx;

    logic [7:0] code;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            seg_q    <= SEG_BLANK;
            last_pat <= SEG_BLANK;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            seg_q    <= bus.seg_in;
            last_pat <= last_pat_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        last_pat_nx = last_pat;
        case (state)
            ST_IDLE: begin
                if (bus.seg_in != last_pat) begin
                    state_nx = ST_SETTLE;
                    cnt_nx   = 4'd0;
                end
            end
            ST_SETTLE: begin
                // Falling back to the already-accepted glyph abandons the candidate.
                if (bus.seg_in == last_pat) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = 4'd0;
                end else if (bus.seg_in != seg_q) begin
                    cnt_nx = 4'd0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = ST_PUSH;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            ST_PUSH: begin
                last_pat_nx = seg_q;
                state_nx    = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // Blank only re-arms repeat detection; it never produces a character.
    assign code = fnd_decode(seg_q);
    assign push = (state == ST_PUSH) && (seg_q != SEG_BLANK);
    assign pop  = !empty && bus.dout_ready;

    fnd_char_fifo u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (push),
        .pop   (pop),
        .din   (code),
        .dout  (bus.dout),
        .full  (full),
        .empty (empty),
        .level (bus.level)
    );

    assign bus.dout_valid = !empty;
    assign bus.err        = push && !fnd_is_mapped(seg_q);
    assign bus.ovf        = push && full && !pop;
    assign bus.state      = state;
endmodule

// File: doc/fnd_decoder.md
FND_DECODER -- requirements
Module: fnd_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical clock samples required before a segment pattern is accepted (legal range 2..15).
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 n_rst  input  1  reset, asynchronous and active-low.
REQ-004 seg_in  input  7  observed 7-segment pattern, active-low, bit0=a .. bit6=g; asynchronous to the producer and possibly glitchy.
REQ-005 dout_ready  input  1  consumer accepts dout this cycle when high.
REQ-006 dout  output  8  ASCII code of the character at the FIFO head.
REQ-007 dout_valid  output  1  high while the FIFO holds at least one character.
REQ-008 level  output  3  FIFO occupancy, 0..4.
REQ-009 err  output  1  one-cycle pulse when an accepted pattern has no code mapping.
REQ-010 ovf  output  1  one-cycle pulse when an accepted character is dropped because the FIFO is full.

Function
REQ-011 seg_q SHALL register seg_in every cycle; the "match" condition is seg_in == seg_q.
REQ-012 The FSM SHALL have states IDLE, SETTLE and PUSH, plus last_pat, the most recently accepted pattern.
REQ-013 IDLE -> SETTLE, with cnt=0, on any edge where seg_in != last_pat.
REQ-014 In SETTLE, a mismatch SHALL clear cnt to 0.
REQ-015 In SETTLE, a match SHALL increment cnt.
REQ-016 In SETTLE, seg_in == last_pat SHALL return the FSM to IDLE with no output.
REQ-017 In SETTLE, a match with cnt == STABLE_CYCLES-1 SHALL move the FSM to PUSH.
REQ-018 PUSH SHALL last exactly one cycle, set last_pat <= seg_q, and return to IDLE.
REQ-019 Decode table (pattern -> ASCII) SHALL be: 1000000->30, 1111001->31, 0100100->32, 0110000->33, 0011001->34, 0010010->35, 0000010->36, 1011000->37, 0000000->38, 0011000->39, 0001000->41, 1000110->43, 0000110->45, 0001110->46, 0001001->48, 1110000->4A.
REQ-020 Ambiguous glyphs (D/0, B/8, I/1, G/6) SHALL decode to the digit.
REQ-021 Blank pattern 1111111 SHALL update last_pat and SHALL NOT write the FIFO; a repeated character therefore requires an intervening blank or other glyph.
REQ-022 An unmapped pattern SHALL push 8'h3F ('?') and pulse err in the PUSH cycle.
REQ-023 A FIFO write SHALL occur at the edge ending PUSH; with STABLE_CYCLES=4 and an empty FIFO, dout_valid SHALL rise 5 edges after the edge that first samples the new pattern.
REQ-024 The FIFO SHALL be 4 entries; dout shows the head combinationally from storage; a pop occurs when dout_valid && dout_ready.
REQ-025 Push when full SHALL drop the character and pulse ovf, unless a pop occurs in the same cycle, in which case the push is accepted.
REQ-026 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave level unchanged; pointers SHALL wrap modulo 4.
REQ-027 dout SHALL be undefined-but-stable (last storage value) when dout_valid is low; consumers SHALL ignore it.

Reset
REQ-028 On n_rst low the block SHALL immediately set state=IDLE, cnt=0, seg_q=7'h7F, last_pat=7'h7F, FIFO empty, dout=8'h00, dout_valid=0, level=0, err=0, ovf=0.
REQ-029 Reset asserted during SETTLE or PUSH SHALL discard the pending character.
REQ-030 Operation SHALL resume on the first edge after n_rst deasserts.

Structure
REQ-031 Shared package fnd_pkg SHALL hold the 7-bit segment pattern constants, the ASCII constants (blank, '?'), and the FSM state enum.
REQ-032 The FIFO SHALL be the sub-module fnd_char_fifo (4x8, push/pop/full/empty/level).
REQ-033 Decode SHALL be a pure function in fnd_pkg, shared in spirit with the existing encoder table.

Verification
REQ-034 Hold 0100100 for 6 cycles after blank -> one dout=8'h32 with dout_valid rising 5 edges after first sample; err=0.
REQ-035 Toggle 0110000/0011001 each cycle for 10 cycles, then hold 0011001 -> only 8'h34 emitted.
REQ-036 Sequence 1111001, blank, 1111001, 0001110 with dout_ready=1 -> dout stream 31, 31, 46; the blank emits nothing.
REQ-037 dout_ready=0, five distinct accepted glyphs -> level=4, one ovf pulse on the fifth; popping then yields the first four in order.
REQ-038 Hold 0101010 for 6 cycles -> dout=8'h3F, err pulse exactly one cycle.
REQ-039 Assert n_rst in the PUSH cycle -> no FIFO write, all outputs at reset values; after release the same held pattern is re-accepted after 5 edges.
